// File: rtl/systolic_feeder.sv
// Operand feeder for an NxN output-stationary systolic array: holds A and B, streams skewed rows/columns on go.
// Optional SYSTOLIC_FEEDER_WERR_EN adds a sticky wr_err flag for writes dropped while busy.
module systolic_feeder #(
    parameter int N  = 4,
    parameter int DW = 8,
    parameter int LW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr_en,
    input  logic            wr_sel,
    input  logic [2*LW-1:0] wr_addr,
    input  logic [DW-1:0]   wr_data,
    input  logic            go,
    output logic            busy,
    output logic [N*DW-1:0] a_edge,
    output logic [N*DW-1:0] b_edge,
    output logic            pe_start,
    output logic            frame_done
`ifdef SYSTOLIC_FEEDER_WERR_EN
    ,
    output logic            wr_err
`endif
);

    localparam int TW = $clog2(3 * N) + 1;
    localparam logic [TW-1:0] T_LAST = TW'(3 * N - 3);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_FIN
    } state_t;

    state_t          state, state_nxt;
    logic [TW-1:0]   t, t_nxt;
    logic            stream_nxt, busy_nxt, done_nxt;
    logic            wr_ok;
    logic [LW-1:0]   wr_row, wr_col;
    logic [DW-1:0]   a_mem [N][N];
    logic [DW-1:0]   b_mem [N][N];
    logic [DW-1:0]   a_fwd [N][N];
    logic [DW-1:0]   b_fwd [N][N];
    logic [N*DW-1:0] a_edge_nxt, b_edge_nxt;

    assign wr_ok  = wr_en && (state == S_IDLE);
    assign wr_row = wr_addr[LW +: LW];
    assign wr_col = wr_addr[0 +: LW];

    // Post-write view of the operands, so a write landing on the go edge is streamed at step 0.
    always_comb begin
        a_fwd = a_mem;
        b_fwd = b_mem;
        if (wr_ok) begin
            if (wr_sel) b_fwd[wr_row][wr_col] = wr_data;
            else        a_fwd[wr_row][wr_col] = wr_data;
        end
    end

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_nxt  = state;
        t_nxt      = t;
        stream_nxt = 1'b0;
        busy_nxt   = 1'b0;
        done_nxt   = 1'b0;
        case (state)
            S_IDLE: begin
                if (go) begin
                    state_nxt  = S_STREAM;
                    t_nxt      = '0;
                    stream_nxt = 1'b1;
                    busy_nxt   = 1'b1;
                end
            end
            S_STREAM: begin
                busy_nxt = 1'b1;
                if (t == T_LAST) begin
                    state_nxt = S_FIN;
                    t_nxt     = '0;
                    done_nxt  = 1'b1;
                end else begin
                    t_nxt      = t + TW'(1);
                    stream_nxt = 1'b1;
                end
            end
            S_FIN: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
                t_nxt     = '0;
            end
        endcase
    end

    // Lane i carries element k of its row/column on step i+k; outside that window it is zero.
    always_comb begin
        a_edge_nxt = '0;
        b_edge_nxt = '0;
        if (stream_nxt) begin
            for (int i = 0; i < N; i++) begin
                for (int k = 0; k < N; k++) begin
                    if (t_nxt == TW'(i + k)) begin
                        a_edge_nxt[i*DW +: DW] = a_fwd[i][k];
                        b_edge_nxt[i*DW +: DW] = b_fwd[k][i];
                    end
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            t          <= '0;
            busy       <= 1'b0;
            pe_start   <= 1'b0;
            frame_done <= 1'b0;
            a_edge     <= '0;
            b_edge     <= '0;
        end else begin
            state      <= state_nxt;
            t          <= t_nxt;
            busy       <= busy_nxt;
            pe_start   <= stream_nxt;
            frame_done <= done_nxt;
            a_edge     <= a_edge_nxt;
            b_edge     <= b_edge_nxt;
        end
    end

    // NOTE: the operand store is a register array that must read back zero after reset, so it is cleared explicitly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    a_mem[r][c] <= '0;
                    b_mem[r][c] <= '0;
                end
            end
        end else begin
            a_mem <= a_fwd;
            b_mem <= b_fwd;
        end
    end

`ifdef SYSTOLIC_FEEDER_WERR_EN
    // Accepting go clears the flag even if a dropped write lands on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_err <= 1'b0;
        end else if ((state == S_IDLE) && go) begin
            wr_err <= 1'b0;
        end else if (wr_en && (state != S_IDLE)) begin
            wr_err <= 1'b1;
        end
    end
`endif

endmodule
